// File: rtl/xf100_exu_decode_pipe_if.sv
// Handshake and decoded-payload bundle between fetch, the decode stage and execute.
// master: the decode stage itself; slave: the upstream/downstream environment.
interface xf100_exu_decode_pipe_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   dec_i_valid;
    logic                   dec_o_ready;
    logic [31:0]            dec_i_instr;
    logic                   dec_i_flush;
    logic                   dec_o_valid;
    logic                   dec_i_ready;
    logic [9:0]             dec_o_alu_info;
    logic                   dec_o_imm_en;
    logic [XLEN-1:0]        dec_o_imm;
    logic                   dec_o_rs1_en;
    logic                   dec_o_rs2_en;
    logic                   dec_o_rd_en;
    logic [RFIDX_WIDTH-1:0] dec_o_rs1_idx;
    logic [RFIDX_WIDTH-1:0] dec_o_rs2_idx;
    logic [RFIDX_WIDTH-1:0] dec_o_rd_idx;
    logic                   dec_o_illegal;
    logic [CNT_WIDTH-1:0]   dec_o_cnt;

    modport master (
        input  dec_i_valid, dec_i_instr, dec_i_flush, dec_i_ready,
        output dec_o_ready, dec_o_valid, dec_o_alu_info, dec_o_imm_en, dec_o_imm,
        output dec_o_rs1_en, dec_o_rs2_en, dec_o_rd_en,
        output dec_o_rs1_idx, dec_o_rs2_idx, dec_o_rd_idx, dec_o_illegal, dec_o_cnt
    );

    modport slave (
        output dec_i_valid, dec_i_instr, dec_i_flush, dec_i_ready,
        input  dec_o_ready, dec_o_valid, dec_o_alu_info, dec_o_imm_en, dec_o_imm,
        input  dec_o_rs1_en, dec_o_rs2_en, dec_o_rd_en,
        input  dec_o_rs1_idx, dec_o_rs2_idx, dec_o_rd_idx, dec_o_illegal, dec_o_cnt
    );
endinterface

// File: rtl/xf100_exu_decode_pipe.sv
// RV32 integer ALU decode stage: decodes R-type and OP-IMM encodings into a one-hot
// ALU select plus operand info, held in a single valid/ready pipeline register.
module xf100_exu_decode_pipe #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xf100_exu_decode_pipe_if.master dec
);

    localparam int unsigned ALU_W    = 10;
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLL  = 2;
    localparam int unsigned ALU_SLT  = 3;
    localparam int unsigned ALU_SLTU = 4;
    localparam int unsigned ALU_XOR  = 5;
    localparam int unsigned ALU_SRL  = 6;
    localparam int unsigned ALU_SRA  = 7;
    localparam int unsigned ALU_OR   = 8;
    localparam int unsigned ALU_AND  = 9;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef struct packed {
        logic [ALU_W-1:0]       alu_info;
        logic                   imm_en;
        logic [XLEN-1:0]        imm;
        logic                   rs1_en;
        logic                   rs2_en;
        logic                   rd_en;
        logic [RFIDX_WIDTH-1:0] rs1_idx;
        logic [RFIDX_WIDTH-1:0] rs2_idx;
        logic [RFIDX_WIDTH-1:0] rd_idx;
        logic                   illegal;
    } payload_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = dec.dec_i_instr[6:0];
    assign rd_f   = dec.dec_i_instr[11:7];
    assign funct3 = dec.dec_i_instr[14:12];
    assign rs1_f  = dec.dec_i_instr[19:15];
    assign rs2_f  = dec.dec_i_instr[24:20];
    assign funct7 = dec.dec_i_instr[31:25];

    logic [ALU_W-1:0] alu_c;
    logic [XLEN-1:0]  imm_c;
    logic             legal_c;
    logic             rtype_c;
    logic [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]  imm_shamt;
    payload_t         nxt_c;

    assign imm_sext  = {{(XLEN-12){dec.dec_i_instr[31]}}, dec.dec_i_instr[31:20]};
    assign imm_shamt = XLEN'(dec.dec_i_instr[24:20]);

    // Instruction decode; anything not explicitly recognised stays illegal.
    always_comb begin
        alu_c   = '0;
        imm_c   = '0;
        legal_c = 1'b0;
        rtype_c = 1'b0;
        case (opcode)
            OP_R: begin
                rtype_c = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal_c = 1'b1;
                    case (funct3)
                        3'b000:  alu_c[ALU_ADD]  = 1'b1;
                        3'b001:  alu_c[ALU_SLL]  = 1'b1;
                        3'b010:  alu_c[ALU_SLT]  = 1'b1;
                        3'b011:  alu_c[ALU_SLTU] = 1'b1;
                        3'b100:  alu_c[ALU_XOR]  = 1'b1;
                        3'b101:  alu_c[ALU_SRL]  = 1'b1;
                        3'b110:  alu_c[ALU_OR]   = 1'b1;
                        default: alu_c[ALU_AND]  = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        legal_c         = 1'b1;
                        alu_c[ALU_SUB]  = 1'b1;
                    end else if (funct3 == 3'b101) begin
                        legal_c         = 1'b1;
                        alu_c[ALU_SRA]  = 1'b1;
                    end
                end
            end
            OP_I: begin
                imm_c = imm_sext;
                case (funct3)
                    3'b000: begin legal_c = 1'b1; alu_c[ALU_ADD]  = 1'b1; end
                    3'b010: begin legal_c = 1'b1; alu_c[ALU_SLT]  = 1'b1; end
                    3'b011: begin legal_c = 1'b1; alu_c[ALU_SLTU] = 1'b1; end
                    3'b100: begin legal_c = 1'b1; alu_c[ALU_XOR]  = 1'b1; end
                    3'b110: begin legal_c = 1'b1; alu_c[ALU_OR]   = 1'b1; end
                    3'b111: begin legal_c = 1'b1; alu_c[ALU_AND]  = 1'b1; end
                    3'b001: begin
                        imm_c = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            legal_c        = 1'b1;
                            alu_c[ALU_SLL] = 1'b1;
                        end
                    end
                    default: begin
                        imm_c = imm_shamt;
                        if (funct7 == F7_BASE) begin
                            legal_c        = 1'b1;
                            alu_c[ALU_SRL] = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            legal_c        = 1'b1;
                            alu_c[ALU_SRA] = 1'b1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
        if (!legal_c) begin
            alu_c = '0;
            imm_c = '0;
        end
    end

    // Next payload; R-type never uses the immediate path.
    always_comb begin
        nxt_c          = '0;
        nxt_c.alu_info = alu_c;
        nxt_c.imm_en   = legal_c & ~rtype_c;
        nxt_c.imm      = rtype_c ? '0 : imm_c;
        nxt_c.rs1_en   = legal_c & (rs1_f != 5'd0);
        nxt_c.rs2_en   = legal_c & rtype_c & (rs2_f != 5'd0);
        nxt_c.rd_en    = legal_c & (rd_f != 5'd0);
        nxt_c.rs1_idx  = RFIDX_WIDTH'(rs1_f);
        nxt_c.rs2_idx  = RFIDX_WIDTH'(rs2_f);
        nxt_c.rd_idx   = RFIDX_WIDTH'(rd_f);
        nxt_c.illegal  = ~legal_c;
    end

    logic                 valid_q;
    payload_t             pl_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ready_c;
    logic                 accept_c;

    assign ready_c  = (~valid_q | dec.dec_i_ready) & rst_n;
    assign accept_c = dec.dec_i_valid & ready_c & ~dec.dec_i_flush;

    // Pipeline register: flush beats accept, accept beats handoff drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (dec.dec_i_flush) begin
                valid_q <= 1'b0;
            end else if (accept_c) begin
                valid_q <= 1'b1;
                pl_q    <= nxt_c;
            end else if (valid_q && dec.dec_i_ready) begin
                valid_q <= 1'b0;
            end
            if (accept_c && legal_c && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign dec.dec_o_ready    = ready_c;
    assign dec.dec_o_valid    = valid_q;
    assign dec.dec_o_alu_info = pl_q.alu_info;
    assign dec.dec_o_imm_en   = pl_q.imm_en;
    assign dec.dec_o_imm      = pl_q.imm;
    assign dec.dec_o_rs1_en   = pl_q.rs1_en;
    assign dec.dec_o_rs2_en   = pl_q.rs2_en;
    assign dec.dec_o_rd_en    = pl_q.rd_en;
    assign dec.dec_o_rs1_idx  = pl_q.rs1_idx;
    assign dec.dec_o_rs2_idx  = pl_q.rs2_idx;
    assign dec.dec_o_rd_idx   = pl_q.rd_idx;
    assign dec.dec_o_illegal  = pl_q.illegal;
    assign dec.dec_o_cnt      = cnt_q;

endmodule

// File: tb/tb_xf100_exu_decode_pipe.sv
// Directed bench for the decode stage; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_xf100_exu_decode_pipe;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    xf100_exu_decode_pipe_if #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(16)) dif ();
    xf100_exu_decode_pipe_if #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(2))  sif ();

    xf100_exu_decode_pipe #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (dif.master)
    );

    xf100_exu_decode_pipe #(.XLEN(32), .RFIDX_WIDTH(5), .CNT_WIDTH(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (sif.master)
    );

    assign sif.dec_i_valid = dif.dec_i_valid;
    assign sif.dec_i_instr = dif.dec_i_instr;
    assign sif.dec_i_flush = dif.dec_i_flush;
    assign sif.dec_i_ready = dif.dec_i_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // en = {rs1_en, rs2_en, rd_en}
    task automatic chk_pl(input string tag, input logic [9:0] alu, input logic imm_en,
                          input logic [31:0] imm, input logic [2:0] en,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic ill, input logic [15:0] cnt);
        chk({tag, ".valid"},   64'(dif.dec_o_valid), 64'(1'b1));
        chk({tag, ".alu"},     64'(dif.dec_o_alu_info), 64'(alu));
        chk({tag, ".imm_en"},  64'(dif.dec_o_imm_en), 64'(imm_en));
        chk({tag, ".imm"},     64'(dif.dec_o_imm), 64'(imm));
        chk({tag, ".en"},      64'({dif.dec_o_rs1_en, dif.dec_o_rs2_en, dif.dec_o_rd_en}), 64'(en));
        chk({tag, ".idx"},     64'({dif.dec_o_rs1_idx, dif.dec_o_rs2_idx, dif.dec_o_rd_idx}),
                               64'({rs1, rs2, rd}));
        chk({tag, ".illegal"}, 64'(dif.dec_o_illegal), 64'(ill));
        chk({tag, ".cnt"},     64'(dif.dec_o_cnt), 64'(cnt));
    endtask

    task automatic send(input logic [31:0] ins);
        dif.dec_i_valid = 1'b1;
        dif.dec_i_instr = ins;
        step();
        dif.dec_i_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n           = 1'b0;
        dif.dec_i_valid = 1'b0;
        dif.dec_i_instr = 32'h0;
        dif.dec_i_flush = 1'b0;
        dif.dec_i_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("rst.cnt",   64'(dif.dec_o_cnt), 64'(16'd0));
        chk("rst.alu",   64'(dif.dec_o_alu_info), 64'(10'd0));
        chk("rst.imm",   64'(dif.dec_o_imm), 64'(32'd0));
        chk("rst.idx",   64'({dif.dec_o_rs1_idx, dif.dec_o_rs2_idx, dif.dec_o_rd_idx}), 64'(15'd0));
        chk("rst.ready", 64'(dif.dec_o_ready), 64'(1'b0));
        rst_n = 1'b1;
        #1;
        chk("rel.ready", 64'(dif.dec_o_ready), 64'(1'b1));

        // Decode vectors, back-to-back with downstream always ready
        send(32'h002081B3);  // add x3,x1,x2
        chk_pl("add", 10'h001, 1'b0, 32'h0, 3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 16'd1);
        chk("add.sat", 64'(sif.dec_o_cnt), 64'(2'd1));
        send(32'hFFF00293);  // addi x5,x0,-1
        chk_pl("addi", 10'h001, 1'b1, 32'hFFFFFFFF, 3'b001, 5'd0, 5'd31, 5'd5, 1'b0, 16'd2);
        send(32'h4040D093);  // srai x1,x1,4
        chk_pl("srai", 10'h080, 1'b1, 32'd4, 3'b101, 5'd1, 5'd4, 5'd1, 1'b0, 16'd3);
        send(32'h40009093);  // slli with funct7 0100000
        chk_pl("ill_slli", 10'h000, 1'b0, 32'h0, 3'b000, 5'd1, 5'd0, 5'd1, 1'b1, 16'd3);
        send(32'h40C58533);  // sub x10,x11,x12
        chk_pl("sub", 10'h002, 1'b0, 32'h0, 3'b111, 5'd11, 5'd12, 5'd10, 1'b0, 16'd4);
        chk("sub.sat", 64'(sif.dec_o_cnt), 64'(2'd3));
        send(32'h40C5A533);  // R-type funct7 0100000 funct3 010
        chk_pl("ill_r", 10'h000, 1'b0, 32'h0, 3'b000, 5'd11, 5'd12, 5'd10, 1'b1, 16'd4);
        send(32'h7FF44393);  // xori x7,x8,0x7ff
        chk_pl("xori", 10'h020, 1'b1, 32'h000007FF, 3'b101, 5'd8, 5'd31, 5'd7, 1'b0, 16'd5);
        send(32'h00000033);  // add x0,x0,x0
        chk_pl("add0", 10'h001, 1'b0, 32'h0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 16'd6);
        send(32'h0000006F);  // jal: unsupported opcode
        chk_pl("ill_op", 10'h000, 1'b0, 32'h0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 16'd6);
        send(32'h01F19113);  // slli x2,x3,31
        chk_pl("slli", 10'h004, 1'b1, 32'd31, 3'b101, 5'd3, 5'd31, 5'd2, 1'b0, 16'd7);

        // Backpressure: A held for three stalled cycles while B waits upstream
        send(32'h0062F233);  // and x4,x5,x6
        chk_pl("and", 10'h200, 1'b0, 32'h0, 3'b111, 5'd5, 5'd6, 5'd4, 1'b0, 16'd8);
        dif.dec_i_ready = 1'b0;
        dif.dec_i_valid = 1'b1;
        dif.dec_i_instr = 32'h00B564B3;  // or x9,x10,x11
        #1;
        chk("bp.ready0", 64'(dif.dec_o_ready), 64'(1'b0));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.ready", 64'(dif.dec_o_ready), 64'(1'b0));
            chk_pl("bp.hold", 10'h200, 1'b0, 32'h0, 3'b111, 5'd5, 5'd6, 5'd4, 1'b0, 16'd8);
        end
        dif.dec_i_ready = 1'b1;
        step();
        chk_pl("bp.or", 10'h100, 1'b0, 32'h0, 3'b111, 5'd10, 5'd11, 5'd9, 1'b0, 16'd9);
        dif.dec_i_instr = 32'h003120B3;  // slt x1,x2,x3
        step();
        chk_pl("bp.slt", 10'h008, 1'b0, 32'h0, 3'b111, 5'd2, 5'd3, 5'd1, 1'b0, 16'd10);
        dif.dec_i_valid = 1'b0;
        step();
        chk("drain.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("drain.cnt", 64'(dif.dec_o_cnt), 64'(16'd10));

        // Flush with a same-cycle accept attempt
        dif.dec_i_valid = 1'b1;
        dif.dec_i_instr = 32'h002081B3;
        dif.dec_i_flush = 1'b1;
        step();
        chk("flush.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("flush.cnt", 64'(dif.dec_o_cnt), 64'(16'd10));
        dif.dec_i_flush = 1'b0;
        dif.dec_i_valid = 1'b0;

        // Flush of a held, stalled instruction
        send(32'h0062F233);
        chk_pl("fh.and", 10'h200, 1'b0, 32'h0, 3'b111, 5'd5, 5'd6, 5'd4, 1'b0, 16'd11);
        dif.dec_i_ready = 1'b0;
        dif.dec_i_flush = 1'b1;
        step();
        chk("fh.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("fh.cnt", 64'(dif.dec_o_cnt), 64'(16'd11));
        chk("fh.sat", 64'(sif.dec_o_cnt), 64'(2'd3));
        dif.dec_i_flush = 1'b0;

        // Reset while an instruction is held and another is offered
        send(32'h0062F233);
        chk("ir.valid1", 64'(dif.dec_o_valid), 64'(1'b1));
        chk("ir.cnt1", 64'(dif.dec_o_cnt), 64'(16'd12));
        dif.dec_i_valid = 1'b1;
        dif.dec_i_instr = 32'h003120B3;
        rst_n = 1'b0;
        step();
        chk("ir.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("ir.cnt", 64'(dif.dec_o_cnt), 64'(16'd0));
        chk("ir.alu", 64'(dif.dec_o_alu_info), 64'(10'd0));
        chk("ir.rd", 64'(dif.dec_o_rd_idx), 64'(5'd0));
        chk("ir.ready", 64'(dif.dec_o_ready), 64'(1'b0));
        chk("ir.sat", 64'(sif.dec_o_cnt), 64'(2'd0));
        rst_n = 1'b1;
        dif.dec_i_valid = 1'b0;
        dif.dec_i_ready = 1'b1;
        step();
        chk("post.valid", 64'(dif.dec_o_valid), 64'(1'b0));
        chk("post.cnt", 64'(dif.dec_o_cnt), 64'(16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
